// File: rtl/mask_scan_ctrl_pkg.sv
// Shared types and constants for the mask scan controller and its counter.
package mask_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] CH_R = 2'd1;
  localparam logic [1:0] CH_G = 2'd2;
  localparam logic [1:0] CH_B = 2'd3;

  localparam logic [7:0] DEF_THRESHOLD = 8'd180;
  localparam logic [1:0] DEF_CHANNEL   = CH_R;

  // Encoding 0 has no channel of its own and selects blue.
  function automatic logic [1:0] norm_channel(input logic [1:0] ch);
    return (ch == 2'd0) ? CH_B : ch;
  endfunction

endpackage

// File: rtl/mask_scan_ctrl_if.sv
// Pixel handshake and coordinate bus between the upstream source, the controller and the mask datapath.
interface mask_scan_ctrl_if #(
  parameter int COORD_W = 11
);
  // A pixel is accepted in any cycle where pix_valid and pix_ready are both high;
  // mask_rw mirrors that acceptance combinationally and coord_x/coord_y name the
  // accepted pixel in that same cycle. pix_valid may drop at any time to stall.
  logic               pix_valid;
  logic               pix_ready;
  logic               mask_rw;
  logic [COORD_W-1:0] coord_x;
  logic [COORD_W-1:0] coord_y;

  modport master (
    output pix_valid,
    input  pix_ready,
    input  mask_rw,
    input  coord_x,
    input  coord_y
  );

  modport slave (
    input  pix_valid,
    output pix_ready,
    output mask_rw,
    output coord_x,
    output coord_y
  );
endinterface

// File: rtl/mask_scan_ctrl_xy_counter.sv
// Raster x/y counter: advances on en, wraps per line and per frame, pulses line_done after a line wrap.
module scan_xy_counter
  import mask_scan_ctrl_pkg::*;
#(
  parameter int WIDTH   = 768,
  parameter int HEIGHT  = 512,
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               line_done_o,
  output logic               last_o
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               line_q, line_d;

  // clr wins over en so an abort never lets a final acceptance advance the raster.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    line_d = 1'b0;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_q == X_MAX) begin
        x_d    = '0;
        line_d = 1'b1;
        y_d    = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      line_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      line_q <= line_d;
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign line_done_o = line_q;
  assign last_o      = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/mask_scan_ctrl.sv
// Frame scan controller: sequences one raster of pixel acceptances and freezes the mask config per frame.
module mask_scan_ctrl
  import mask_scan_ctrl_pkg::*;
#(
  parameter int WIDTH   = 768,
  parameter int HEIGHT  = 512,
  parameter int COORD_W = 11
) (
  input  logic                   CAMERA_CLK,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cfg_valid,
  input  logic [1:0]             cfg_channel,
  input  logic [7:0]             cfg_threshold,
  mask_scan_ctrl_if.slave        pix,
  output logic [1:0]             sel_channel,
  output logic [7:0]             threshold,
  output logic                   busy,
  output logic                   line_done,
  output logic                   frame_done,
  output state_e                 dbg_state_o
);

  state_e             state_q, state_d;
  logic               ready;
  logic               accept;
  logic               abort_hit;
  logic               last_px;
  logic [COORD_W-1:0] x, y;

  logic [1:0] pend_ch_q, pend_ch_d, act_ch_q, act_ch_d;
  logic [7:0] pend_th_q, pend_th_d, act_th_q, act_th_d;

  assign accept    = pix.pix_valid & ready;
  assign abort_hit = abort & (state_q inside {ST_ARM, ST_SCAN, ST_DRAIN});

  always_ff @(posedge CAMERA_CLK) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_ARM;
        ST_ARM:   state_d = ST_SCAN;
        ST_SCAN:  if (accept && last_px) state_d = ST_DRAIN;
        ST_DRAIN: state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ready      = (state_q == ST_SCAN);
    busy       = (state_q == ST_ARM) || (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    frame_done = (state_q == ST_DONE);
  end

  // Pending config is written any time; the active copy is taken from the value
  // registered before ARM, so a write landing in ARM waits for the next frame.
  always_comb begin
    pend_ch_d = pend_ch_q;
    pend_th_d = pend_th_q;
    act_ch_d  = act_ch_q;
    act_th_d  = act_th_q;
    if (cfg_valid) begin
      pend_ch_d = norm_channel(cfg_channel);
      pend_th_d = cfg_threshold;
    end
    if (state_q == ST_ARM) begin
      act_ch_d = pend_ch_q;
      act_th_d = pend_th_q;
    end
  end

  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      pend_ch_q <= DEF_CHANNEL;
      pend_th_q <= DEF_THRESHOLD;
      act_ch_q  <= DEF_CHANNEL;
      act_th_q  <= DEF_THRESHOLD;
    end else begin
      pend_ch_q <= pend_ch_d;
      pend_th_q <= pend_th_d;
      act_ch_q  <= act_ch_d;
      act_th_q  <= act_th_d;
    end
  end

  scan_xy_counter #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .COORD_W (COORD_W)
  ) u_xy (
    .clk         (CAMERA_CLK),
    .rst         (rst),
    .en          (accept & ~abort_hit),
    .clr         (abort_hit),
    .x_o         (x),
    .y_o         (y),
    .line_done_o (line_done),
    .last_o      (last_px)
  );

  assign pix.pix_ready = ready;
  assign pix.mask_rw   = accept;
  assign pix.coord_x   = x;
  assign pix.coord_y   = y;
  assign sel_channel   = act_ch_q;
  assign threshold     = act_th_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mask_scan_ctrl.sv
// Directed bench for mask_scan_ctrl on a 4x2 frame, checked every cycle against a raster/phase model.
module tb_mask_scan_ctrl;
  import mask_scan_ctrl_pkg::*;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int CW = 11;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_channel = 2'd0;
  logic [7:0] cfg_threshold = 8'd0;
  logic [1:0] sel_channel;
  logic [7:0] threshold;
  logic       busy, line_done, frame_done;
  state_e     dbg_state;

  always #5 clk = ~clk;

  mask_scan_ctrl_if #(.COORD_W(CW)) pix ();
  initial pix.pix_valid = 1'b0;

  mask_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW)) dut (
    .CAMERA_CLK    (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_valid     (cfg_valid),
    .cfg_channel   (cfg_channel),
    .cfg_threshold (cfg_threshold),
    .pix           (pix),
    .sel_channel   (sel_channel),
    .threshold     (threshold),
    .busy          (busy),
    .line_done     (line_done),
    .frame_done    (frame_done),
    .dbg_state_o   (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  // Phase: 0 idle, 1 arm, 2 scan, 3 drain, 4 done. exp_q holds the raster
  // coordinates still to be accepted this frame, {y, x}.
  logic [2*CW-1:0] exp_q[$];
  int         m_phase = 0;
  bit         m_on = 0;
  bit         m_ld = 0;
  logic [1:0] m_pend_ch = 2'd1, m_act_ch = 2'd1;
  logic [7:0] m_pend_th = 8'd180, m_act_th = 8'd180;

  always @(posedge clk) begin
    bit acc;
    bit ab;
    logic [2*CW-1:0] head;
    if (rst) begin
      m_on = 1;
      m_phase = 0;
      exp_q.delete();
      m_ld = 0;
      m_pend_ch = 2'd1; m_pend_th = 8'd180;
      m_act_ch  = 2'd1; m_act_th  = 8'd180;
    end else if (m_on) begin
      acc  = pix.pix_valid && (m_phase == 2);
      ab   = abort && (m_phase >= 1) && (m_phase <= 3);
      m_ld = 0;
      if (m_phase == 1) begin
        m_act_ch = m_pend_ch;
        m_act_th = m_pend_th;
      end
      if (cfg_valid) begin
        m_pend_ch = (cfg_channel == 2'd0) ? 2'd3 : cfg_channel;
        m_pend_th = cfg_threshold;
      end
      if (ab) begin
        m_phase = 0;
        exp_q.delete();
      end else begin
        case (m_phase)
          0: if (start) begin
               m_phase = 1;
               for (int yy = 0; yy < H; yy++)
                 for (int xx = 0; xx < W; xx++)
                   exp_q.push_back({CW'(yy), CW'(xx)});
             end
          1: m_phase = 2;
          2: if (acc) begin
               head = exp_q.pop_front();
               m_ld = (head[CW-1:0] == CW'(W - 1));
               if (exp_q.size() == 0) m_phase = 3;
             end
          3: m_phase = 4;
          default: m_phase = 0;
        endcase
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int cyc = 0, acc_cnt = 0, ld_cnt = 0, fd_cnt = 0;
  int last_acc_cyc = 0, fd_cyc = 0;
  logic [CW-1:0] last_x, last_y;

  always @(negedge clk) begin
    logic [2*CW-1:0] head;
    if (m_on && !rst) begin
      cyc++;
      check("pix_ready",   pix.pix_ready, m_phase == 2);
      check("mask_rw",     pix.mask_rw, pix.pix_valid && (m_phase == 2));
      check("busy",        busy, (m_phase >= 1) && (m_phase <= 3));
      check("line_done",   line_done, m_ld);
      check("frame_done",  frame_done, m_phase == 4);
      check("sel_channel", sel_channel, m_act_ch);
      check("threshold",   threshold, m_act_th);
      if (m_phase == 2 && exp_q.size() > 0) begin
        head = exp_q[0];
        check("coord_x", pix.coord_x, head[CW-1:0]);
        check("coord_y", pix.coord_y, head[2*CW-1:CW]);
      end else if (m_phase <= 1) begin
        check("coord_x_idle", pix.coord_x, 0);
        check("coord_y_idle", pix.coord_y, 0);
      end
      if (pix.mask_rw) begin
        acc_cnt++;
        last_acc_cyc = cyc;
        last_x = pix.coord_x;
        last_y = pix.coord_y;
      end
      if (line_done) ld_cnt++;
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();  // returns inside the ARM cycle
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_fd(input int budget);
    int f0;
    f0 = fd_cnt;
    for (int i = 0; i < budget && fd_cnt == f0; i++) tick();
    check("frame_done_within_budget", fd_cnt != f0, 1);
  endtask

  task automatic do_cfg(input logic [1:0] ch, input logic [7:0] th);
    cfg_valid = 1'b1; cfg_channel = ch; cfg_threshold = th;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, l0, f0;

    // reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_threshold", threshold, 180);
    check("rst_channel", sel_channel, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", pix.pix_ready, 0);
    check("rst_coord_x", pix.coord_x, 0);

    // full frame with continuous valid
    tick();
    pix.pix_valid = 1'b1;
    a0 = acc_cnt; l0 = ld_cnt; f0 = fd_cnt;
    start_frame();
    wait_fd(40);
    check("f1_accepts", acc_cnt - a0, 8);
    check("f1_line_done", ld_cnt - l0, 2);
    check("f1_frame_done", fd_cnt - f0, 1);
    check("f1_fd_latency", fd_cyc - last_acc_cyc, 2);
    check("f1_last_x", last_x, 3);
    check("f1_last_y", last_y, 1);

    // config taken at ARM, held through the frame
    do_cfg(2'd2, 8'd100);
    tick();
    cfg_valid = 1'b0;
    start_frame();
    tick();
    @(negedge clk);
    check("cfg_armp1_channel", sel_channel, 2);
    check("cfg_armp1_threshold", threshold, 100);
    tick();
    do_cfg(2'd3, 8'd50);
    tick();
    cfg_valid = 1'b0;
    @(negedge clk);
    check("cfg_midscan_channel", sel_channel, 2);
    check("cfg_midscan_threshold", threshold, 100);
    wait_fd(40);

    // write in the ARM cycle goes to pending only
    start_frame();
    do_cfg(2'd0, 8'd77);
    tick();
    cfg_valid = 1'b0;
    @(negedge clk);
    check("cfg_arm_write_channel", sel_channel, 3);
    check("cfg_arm_write_threshold", threshold, 50);
    wait_fd(40);

    // valid toggling 1010
    a0 = acc_cnt; f0 = fd_cnt;
    start_frame();
    tick();
    @(negedge clk);
    check("cfg_next_frame_channel", sel_channel, 3);
    check("cfg_next_frame_threshold", threshold, 77);
    for (int i = 0; i < 80 && fd_cnt == f0; i++) begin
      pix.pix_valid = (i % 2 == 0);
      tick();
    end
    check("toggle_frame_done", fd_cnt - f0, 1);
    check("toggle_accepts", acc_cnt - a0, 8);
    pix.pix_valid = 1'b1;

    // abort at (2,1)
    f0 = fd_cnt;
    start_frame();
    repeat (7) tick();
    abort = 1'b1;
    @(negedge clk);
    check("abort_at_x", pix.coord_x, 2);
    check("abort_at_y", pix.coord_y, 1);
    check("abort_cycle_mask_rw", pix.mask_rw, 1);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_coord_x", pix.coord_x, 0);
    check("abort_coord_y", pix.coord_y, 0);
    repeat (5) tick();
    check("abort_no_frame_done", fd_cnt - f0, 0);
    a0 = acc_cnt; l0 = ld_cnt;
    start_frame();
    wait_fd(40);
    check("post_abort_accepts", acc_cnt - a0, 8);
    check("post_abort_line_done", ld_cnt - l0, 2);

    // start held for a whole frame
    f0 = fd_cnt;
    start = 1'b1;
    wait_fd(40);
    check("held_start_one_frame", fd_cnt - f0, 1);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("held_start_new_frame_busy", busy, 1);
    wait_fd(40);

    // reset mid-scan overrides start/abort/cfg
    f0 = fd_cnt;
    start_frame();
    repeat (3) tick();
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    do_cfg(2'd2, 8'd99);
    tick();
    rst = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    check("midrst_threshold", threshold, 180);
    check("midrst_channel", sel_channel, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ready", pix.pix_ready, 0);
    check("midrst_coord_x", pix.coord_x, 0);
    check("midrst_coord_y", pix.coord_y, 0);
    check("midrst_line_done", line_done, 0);
    repeat (4) tick();
    check("midrst_no_frame_done", fd_cnt - f0, 0);
    start_frame();
    tick();
    @(negedge clk);
    check("midrst_pending_channel", sel_channel, 1);
    check("midrst_pending_threshold", threshold, 180);
    wait_fd(40);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
